button_debounce: RTL
====================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameters SHALL be:
- DEBOUNCE_CYCLES, default 4: consecutive stable samples required; legal range 2..2^20.
- BTN_ACTIVE_HIGH, default 1: 1 means btn_in high = pressed; 0 means btn_in low = pressed.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  input  1  single clock.
- rst_n  input  1  asynchronous, active-low reset.
- btn_in  input  1  raw mechanical button, asynchronous to clk.
- enable_pulse  output  1  one-cycle strobe per debounced press; drives a downstream counter enable.
- btn_level  output  1  debounced pressed level, 1 = pressed.
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 btn_in SHALL pass through a two-flop synchronizer; the result, normalised so 1 = pressed, is btn_s.
REQ-005 The FSM SHALL have four states: IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE.
REQ-006 Transitions from IDLE:
- btn_s=1 -> WAIT_PRESS, cnt=1.
- otherwise stay in IDLE, cnt=0.
REQ-007 Transitions from WAIT_PRESS:
- btn_s=0 -> IDLE, cnt=0.
- btn_s=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED, cnt=0.
- otherwise cnt+1.
REQ-008 Transitions from PRESSED:
- btn_s=0 -> WAIT_RELEASE, cnt=1.
- otherwise stay, cnt=0.
REQ-009 Transitions from WAIT_RELEASE:
- btn_s=1 -> PRESSED, cnt=0.
- btn_s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, cnt=0.
- otherwise cnt+1.
REQ-010 enable_pulse SHALL be registered and high for exactly one cycle, in the cycle after the WAIT_PRESS->PRESSED transition edge; it SHALL be low at all other times.
REQ-011 Press latency: with btn_in held pressed from edge E0, enable_pulse SHALL be high in the cycle after edge E0+DEBOUNCE_CYCLES+1 (total DEBOUNCE_CYCLES+2 edges).
REQ-012 btn_level SHALL be 1 in PRESSED and WAIT_RELEASE and 0 in IDLE and WAIT_PRESS; it SHALL rise in the same cycle as enable_pulse.
REQ-013 A bounce shorter than DEBOUNCE_CYCLES samples SHALL produce no enable_pulse and no change in btn_level.
REQ-014 A single press held indefinitely SHALL produce exactly one enable_pulse, with no auto-repeat.
REQ-015 A release glitch shorter than DEBOUNCE_CYCLES samples during PRESSED SHALL NOT produce a second pulse.
REQ-016 cnt width SHALL be clog2(DEBOUNCE_CYCLES); cnt SHALL never exceed DEBOUNCE_CYCLES-1, so it never wraps.

Reset
REQ-017 While rst_n=0, state SHALL be IDLE, cnt=0, and both synchronizer flops SHALL hold the released level (~BTN_ACTIVE_HIGH).
REQ-018 While rst_n=0, enable_pulse and btn_level SHALL be 0.
REQ-019 Reset asserted mid-debounce or mid-pulse SHALL immediately clear the block, and the interrupted pulse SHALL NOT be emitted after reset.
REQ-020 A button held pressed through reset deassertion SHALL be treated as a new press, giving one pulse per REQ-011.

Structure
REQ-021 The state encodings SHALL be defined as 2-bit constants in the shared package debounce_pkg: IDLE=0, WAIT_PRESS=1, PRESSED=2, WAIT_RELEASE=3.
REQ-022 The synchronizer SHALL be the sub-module sync_2ff (ports clk, rst_n, d, q, reset value parameter); there SHALL be no other sub-modules.
REQ-023 enable_pulse SHALL connect directly to the enable input of the 4-bit counter with no extra glue logic.

Verification (DEBOUNCE_CYCLES=4, BTN_ACTIVE_HIGH=1)
REQ-024 Clean press: btn_in 0->1 before edge 0 and held -> enable_pulse high only in the cycle after edge 5; btn_level=1 from that cycle onward.
REQ-025 Bounce: btn_in pattern 1,0,1,1,0,1,1,0 (one value per cycle), then 0 -> enable_pulse never asserted, btn_level stays 0.
REQ-026 Hold 100 cycles, then release for 10 cycles, then press again -> exactly 2 pulses in total; btn_level falls 6 edges after the release.
REQ-027 Reset mid-debounce: rst_n=0 at edge 3 of a press -> no pulse; with btn_in still held, exactly one pulse 6 edges after rst_n release.
REQ-028 Counter chain: 5 clean presses feeding the 4-bit counter -> count==5; 16 clean presses -> count==0.
REQ-029 BTN_ACTIVE_HIGH=0: btn_in 1->0 held -> pulse in the cycle after edge 5; idle-high input -> no pulse.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared FSM encodings and helpers for the button debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  // Debounced level is "pressed" once the press has been accepted, including
  // while a release is still being qualified.
  function automatic logic level_of(state_t s);
    return (s == PRESSED) || (s == WAIT_RELEASE);
  endfunction

  function automatic int cnt_width(int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a programmable
// reset value so the idle level can be held while in reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Debounces a raw mechanical button and emits one registered strobe per
// accepted press plus a debounced pressed level.
module button_debounce
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit BTN_ACTIVE_HIGH = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic enable_pulse,
  output logic btn_level
);

  localparam int               CNT_W     = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic             REL_LEVEL = logic'(!BTN_ACTIVE_HIGH);

  logic             btn_sync;
  logic             btn_s;
  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] next_cnt;
  logic             press_done;

  sync_2ff #(
    .RESET_VAL(REL_LEVEL)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (btn_in),
    .q    (btn_sync)
  );

  assign btn_s = BTN_ACTIVE_HIGH ? btn_sync : ~btn_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      enable_pulse <= 1'b0;
    end else begin
      state        <= next_state;
      cnt          <= next_cnt;
      enable_pulse <= press_done;
    end
  end

  // cnt only advances while qualifying and is cleared on every state change,
  // so it tops out at CNT_LAST and never wraps.
  always_comb begin
    next_state = state;
    next_cnt   = '0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          next_state = WAIT_PRESS;
          next_cnt   = CNT_ONE;
        end
      end
      WAIT_PRESS: begin
        if (!btn_s) begin
          next_state = IDLE;
        end else if (cnt == CNT_LAST) begin
          next_state = PRESSED;
        end else begin
          next_cnt = cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          next_state = WAIT_RELEASE;
          next_cnt   = CNT_ONE;
        end
      end
      WAIT_RELEASE: begin
        if (btn_s) begin
          next_state = PRESSED;
        end else if (cnt == CNT_LAST) begin
          next_state = IDLE;
        end else begin
          next_cnt = cnt + CNT_ONE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_comb begin
    btn_level  = level_of(state);
    press_done = (state == WAIT_PRESS) && (next_state == PRESSED);
  end

endmodule
